// File: rtl/mem_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the instruction/data memory-bus arbiter.
//   arb_state_t : sequencer states (IDLE -> FETCH|DATA -> DONE -> IDLE)
//   grant_t     : which CPU port owns the current/last transaction
//   BE_ALL      : byte enables used for instruction fetches (full word)
//   word_align  : clears the two byte-offset bits of a byte address
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam logic [3:0]  BE_ALL    = 4'b1111;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // The bus is word addressed in practice; the byte offset is carried by
  // byteenable, so the low address bits are always presented as zero.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return byte_addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// Interfaces around the memory-bus arbiter.
//
// mem_arb_cpu_if : the two CPU-side request ports.
//   master modport = CPU core (drives requests, receives ready/rdata)
//   slave  modport = arbiter  (receives requests, drives ready/rdata)
//   if_req/if_addr                 fetch request, held until if_ready
//   if_rdata/if_ready              fetched word + 1-cycle completion pulse
//   d_read/d_write/d_addr/d_wdata/d_byteenable  load/store request, held until d_ready
//   d_rdata/d_ready                load word (0 for stores) + 1-cycle completion pulse
//
// mem_arb_avalon_if : the shared Avalon-style memory bus.
//   master modport = arbiter (drives address/strobes/write data)
//   slave  modport = memory  (drives readdata/waitrequest)
// ----------------------------------------------------------------------------
interface mem_arb_cpu_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_ready;

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
    input  if_rdata, if_ready, d_rdata, d_ready
  );

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
    output if_rdata, if_ready, d_rdata, d_ready
  );
endinterface

interface mem_arb_avalon_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// ----------------------------------------------------------------------------
// mem_arb_watchdog
//   Saturating stall counter guarding one bus transaction.
//   clk      : clock
//   reset    : asynchronous, active-high
//   clear    : zero the count (held while the arbiter is idle, i.e. on grant)
//   count_en : one stall cycle observed this cycle
//   limit    : number of stall cycles tolerated
//   expired  : this stall cycle is the limit-th one; abort at the coming edge
// ----------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  // count_reg holds the stalls already completed, so the current stall is
  // number count_reg+1; flag it when that equals the limit.
  assign expired = count_en && (count_reg >= (limit - ONE));

endmodule

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one Avalon-style memory bus between the CPU instruction-fetch port
//   and the load/store port, one transaction at a time. A request is sampled
//   in IDLE, the bus strobe is driven from the next cycle until waitrequest
//   drops (or the watchdog aborts it), and the granted port then gets a single
//   ready pulse with the registered read data.
//
// Parameters
//   DATA_PRIORITY  : 1 = data port wins a tie, 0 = alternate on a tie
//   TIMEOUT_CYCLES : stall cycles tolerated before abort (>= 1)
// Ports
//   clk       : clock, all state on posedge
//   reset     : asynchronous, active-high; drops any in-flight transaction
//   cpu       : CPU request/response ports (slave side)
//   bus       : memory bus (master side); every output is a register
//   bus_error : sticky; set on timeout or on a simultaneous load+store
// ----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_arb_cpu_if.slave       cpu,
  mem_arb_avalon_if.master   bus,
  output logic               bus_error
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t state_reg;
  grant_t     gnt_reg;
  grant_t     last_grant_reg;

  logic data_pending;
  logic pick_data;
  logic wd_clear;
  logic wd_count_en;
  logic wd_expired;

  // --------------------------------------------------------------------------
  // Grant decision (only consulted in IDLE)
  // --------------------------------------------------------------------------
  assign data_pending = cpu.d_read | cpu.d_write;

  always_comb begin
    pick_data = 1'b0;
    if (data_pending && cpu.if_req) begin
      if (DATA_PRIORITY != 0) begin
        pick_data = 1'b1;
      end else begin
        // Alternate on a tie: hand the bus to whichever port did not
        // own the previous transaction.
        pick_data = (last_grant_reg == GNT_FETCH);
      end
    end else begin
      pick_data = data_pending;
    end
  end

  // --------------------------------------------------------------------------
  // Stall watchdog: cleared while idle, so every grant starts from zero
  // --------------------------------------------------------------------------
  assign wd_clear    = (state_reg == IDLE);
  assign wd_count_en = ((state_reg == FETCH) || (state_reg == DATA)) && bus.waitrequest;

  mem_arb_watchdog #(
    .WIDTH (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .limit    (LIMIT),
    .expired  (wd_expired)
  );

  // --------------------------------------------------------------------------
  // Sequencer with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      gnt_reg        <= GNT_FETCH;
      last_grant_reg <= GNT_FETCH;
      bus.address    <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
      cpu.if_rdata   <= '0;
      cpu.if_ready   <= 1'b0;
      cpu.d_rdata    <= '0;
      cpu.d_ready    <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      // Ready strobes are single-cycle; they are only raised on the edge
      // that enters DONE.
      cpu.if_ready <= 1'b0;
      cpu.d_ready  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pick_data) begin
            state_reg      <= DATA;
            gnt_reg        <= GNT_DATA;
            bus.address    <= word_align(cpu.d_addr);
            bus.byteenable <= cpu.d_byteenable;
            bus.writedata  <= cpu.d_wdata;
            // A load and store together is a protocol error; the store
            // wins so read and write are never asserted together.
            bus.write      <= cpu.d_write;
            bus.read       <= cpu.d_read & ~cpu.d_write;
            if (cpu.d_read && cpu.d_write) begin
              bus_error <= 1'b1;
            end
          end else if (cpu.if_req) begin
            state_reg      <= FETCH;
            gnt_reg        <= GNT_FETCH;
            bus.address    <= word_align(cpu.if_addr);
            bus.byteenable <= BE_ALL;
            bus.writedata  <= '0;
            bus.read       <= 1'b1;
            bus.write      <= 1'b0;
          end
        end

        FETCH: begin
          if (!bus.waitrequest) begin
            bus.read     <= 1'b0;
            cpu.if_rdata <= bus.readdata;
            cpu.if_ready <= 1'b1;
            state_reg    <= DONE;
          end else if (wd_expired) begin
            bus.read     <= 1'b0;
            bus_error    <= 1'b1;
            cpu.if_rdata <= '0;
            cpu.if_ready <= 1'b1;
            state_reg    <= DONE;
          end
        end

        DATA: begin
          if (!bus.waitrequest) begin
            bus.read    <= 1'b0;
            bus.write   <= 1'b0;
            // Stores complete with zero data rather than stale bus data.
            cpu.d_rdata <= bus.write ? '0 : bus.readdata;
            cpu.d_ready <= 1'b1;
            state_reg   <= DONE;
          end else if (wd_expired) begin
            bus.read    <= 1'b0;
            bus.write   <= 1'b0;
            bus_error   <= 1'b1;
            cpu.d_rdata <= '0;
            cpu.d_ready <= 1'b1;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // Requests are not sampled here; a port asserting now waits one
          // more cycle for IDLE.
          last_grant_reg <= gnt_reg;
          state_reg      <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          bus.read  <= 1'b0;
          bus.write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Three instances share clk/reset:
//     u_main : DATA_PRIORITY=1, TIMEOUT_CYCLES=255
//     u_rr   : DATA_PRIORITY=0, TIMEOUT_CYCLES=255
//     u_to   : DATA_PRIORITY=1, TIMEOUT_CYCLES=4
//   Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;
  logic err_m, err_r, err_t;

  int checks;
  int passed;

  mem_arb_cpu_if    cpu_m ();
  mem_arb_avalon_if bus_m ();
  mem_arb_cpu_if    cpu_r ();
  mem_arb_avalon_if bus_r ();
  mem_arb_cpu_if    cpu_t ();
  mem_arb_avalon_if bus_t ();

  mem_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(255)) u_main (
    .clk(clk), .reset(reset), .cpu(cpu_m), .bus(bus_m), .bus_error(err_m));
  mem_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(255)) u_rr (
    .clk(clk), .reset(reset), .cpu(cpu_r), .bus(bus_r), .bus_error(err_r));
  mem_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_to (
    .clk(clk), .reset(reset), .cpu(cpu_t), .bus(bus_t), .bus_error(err_t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1, "bench timed out");
  end

  task automatic idle_inputs();
    cpu_m.if_req = 0; cpu_m.if_addr = 0; cpu_m.d_read = 0; cpu_m.d_write = 0;
    cpu_m.d_addr = 0; cpu_m.d_wdata = 0; cpu_m.d_byteenable = 0;
    bus_m.readdata = 0; bus_m.waitrequest = 0;
    cpu_r.if_req = 0; cpu_r.if_addr = 0; cpu_r.d_read = 0; cpu_r.d_write = 0;
    cpu_r.d_addr = 0; cpu_r.d_wdata = 0; cpu_r.d_byteenable = 0;
    bus_r.readdata = 0; bus_r.waitrequest = 0;
    cpu_t.if_req = 0; cpu_t.if_addr = 0; cpu_t.d_read = 0; cpu_t.d_write = 0;
    cpu_t.d_addr = 0; cpu_t.d_wdata = 0; cpu_t.d_byteenable = 0;
    bus_t.readdata = 0; bus_t.waitrequest = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b0) $display("FAIL rst_read: got %b want 0", bus_m.read); else passed++;
    checks++; if (bus_m.write !== 1'b0) $display("FAIL rst_write: got %b want 0", bus_m.write); else passed++;
    checks++; if (bus_m.address !== 32'h0) $display("FAIL rst_address: got %h want 0", bus_m.address); else passed++;
    checks++; if (bus_m.writedata !== 32'h0) $display("FAIL rst_writedata: got %h want 0", bus_m.writedata); else passed++;
    checks++; if (bus_m.byteenable !== 4'h0) $display("FAIL rst_byteenable: got %h want 0", bus_m.byteenable); else passed++;
    checks++; if ({cpu_m.if_ready, cpu_m.d_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {cpu_m.if_ready, cpu_m.d_ready}); else passed++;
    checks++; if ({cpu_m.if_rdata, cpu_m.d_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {cpu_m.if_rdata, cpu_m.d_rdata}); else passed++;
    checks++; if ({err_m, err_r, err_t} !== 3'b000) $display("FAIL rst_bus_error: got %b want 000", {err_m, err_r, err_t}); else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b0) $display("FAIL rst_idle_read: got %b want 0", bus_m.read); else passed++;
    $display("reset released");
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    cpu_m.if_req = 1; cpu_m.if_addr = 32'h0000_0103;
    bus_m.waitrequest = 0; bus_m.readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b1) $display("FAIL fetch_read: got %b want 1", bus_m.read); else passed++;
    checks++; if (bus_m.write !== 1'b0) $display("FAIL fetch_write: got %b want 0", bus_m.write); else passed++;
    checks++; if (bus_m.address !== 32'h0000_0100) $display("FAIL fetch_address: got %h want 00000100", bus_m.address); else passed++;
    checks++; if (bus_m.byteenable !== 4'hF) $display("FAIL fetch_byteenable: got %h want f", bus_m.byteenable); else passed++;
    checks++; if (cpu_m.if_ready !== 1'b0) $display("FAIL fetch_early_ready: got %b want 0", cpu_m.if_ready); else passed++;
    @(negedge clk);
    checks++; if (cpu_m.if_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", cpu_m.if_ready); else passed++;
    checks++; if (cpu_m.if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h want deadbeef", cpu_m.if_rdata); else passed++;
    checks++; if (bus_m.read !== 1'b0) $display("FAIL fetch_done_read: got %b want 0", bus_m.read); else passed++;
    cpu_m.if_req = 0;
    $display("fetch addr=00000103 rdata=%h", cpu_m.if_rdata);
    @(negedge clk);
    checks++; if (cpu_m.if_ready !== 1'b0) $display("FAIL fetch_pulse_width: got %b want 0", cpu_m.if_ready); else passed++;
  endtask

  task automatic test_data_priority();
    @(negedge clk);
    cpu_m.if_req = 1; cpu_m.if_addr = 32'h0000_0200;
    cpu_m.d_write = 1; cpu_m.d_addr = 32'h0000_0010; cpu_m.d_wdata = 32'h1234_5678;
    cpu_m.d_byteenable = 4'b0011; bus_m.readdata = 32'hFFFF_FFFF; bus_m.waitrequest = 0;
    @(negedge clk);
    checks++; if ({bus_m.write, bus_m.read} !== 2'b10) $display("FAIL prio_strobe: got %b want 10", {bus_m.write, bus_m.read}); else passed++;
    checks++; if (bus_m.address !== 32'h0000_0010) $display("FAIL prio_address: got %h want 00000010", bus_m.address); else passed++;
    checks++; if (bus_m.byteenable !== 4'b0011) $display("FAIL prio_byteenable: got %b want 0011", bus_m.byteenable); else passed++;
    checks++; if (bus_m.writedata !== 32'h1234_5678) $display("FAIL prio_writedata: got %h want 12345678", bus_m.writedata); else passed++;
    @(negedge clk);
    checks++; if ({cpu_m.d_ready, cpu_m.if_ready} !== 2'b10) $display("FAIL prio_d_ready: got %b want 10", {cpu_m.d_ready, cpu_m.if_ready}); else passed++;
    checks++; if (cpu_m.d_rdata !== 32'h0) $display("FAIL prio_store_rdata: got %h want 0", cpu_m.d_rdata); else passed++;
    checks++; if (bus_m.write !== 1'b0) $display("FAIL prio_done_write: got %b want 0", bus_m.write); else passed++;
    cpu_m.d_write = 0;
    $display("store addr=00000010 wdata=12345678 be=0011");
    @(negedge clk);
    checks++; if ({bus_m.read, bus_m.write} !== 2'b00) $display("FAIL prio_idle_strobe: got %b want 00", {bus_m.read, bus_m.write}); else passed++;
    bus_m.readdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b1) $display("FAIL prio_fetch_read: got %b want 1", bus_m.read); else passed++;
    checks++; if (bus_m.address !== 32'h0000_0200) $display("FAIL prio_fetch_address: got %h want 00000200", bus_m.address); else passed++;
    @(negedge clk);
    checks++; if ({cpu_m.if_ready, cpu_m.d_ready} !== 2'b10) $display("FAIL prio_if_ready: got %b want 10", {cpu_m.if_ready, cpu_m.d_ready}); else passed++;
    checks++; if (cpu_m.if_rdata !== 32'hCAFE_F00D) $display("FAIL prio_if_rdata: got %h want cafef00d", cpu_m.if_rdata); else passed++;
    cpu_m.if_req = 0;
    $display("fetch addr=00000200 rdata=%h", cpu_m.if_rdata);
  endtask

  task automatic test_round_robin();
    logic [1:0] got;
    logic [1:0] want;
    logic       seen;
    @(negedge clk);
    cpu_r.if_req = 1; cpu_r.if_addr = 32'h0000_0500;
    cpu_r.d_read = 1; cpu_r.d_addr = 32'h0000_0600; cpu_r.d_byteenable = 4'hF;
    bus_r.readdata = 32'h1111_2222; bus_r.waitrequest = 0;
    for (int t = 0; t < 4; t++) begin
      got  = 2'b00;
      seen = 1'b0;
      want = (t % 2 == 0) ? 2'b10 : 2'b01;   // {data, fetch}
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        if (cpu_r.if_ready || cpu_r.d_ready) begin
          seen = 1'b1;
          got  = {cpu_r.d_ready, cpu_r.if_ready};
        end
      end
      checks++; if (got !== want) $display("FAIL rr_grant%0d: got %b want %b", t, got, want); else passed++;
      $display("rr transaction %0d grant {d,f}=%b", t, got);
    end
    cpu_r.if_req = 0; cpu_r.d_read = 0;
  endtask

  task automatic test_stall();
    @(negedge clk);
    cpu_m.d_read = 1; cpu_m.d_addr = 32'h0000_0044; cpu_m.d_byteenable = 4'hF;
    bus_m.waitrequest = 1; bus_m.readdata = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if ({bus_m.read, bus_m.address} !== {1'b1, 32'h0000_0044}) $display("FAIL stall_hold%0d: got %b/%h want 1/00000044", k, bus_m.read, bus_m.address); else passed++;
      checks++; if (cpu_m.d_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", k, cpu_m.d_ready); else passed++;
    end
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b1) $display("FAIL stall_read6: got %b want 1", bus_m.read); else passed++;
    bus_m.waitrequest = 0; bus_m.readdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (cpu_m.d_ready !== 1'b1) $display("FAIL stall_d_ready: got %b want 1", cpu_m.d_ready); else passed++;
    checks++; if (cpu_m.d_rdata !== 32'h0BAD_F00D) $display("FAIL stall_d_rdata: got %h want 0badf00d", cpu_m.d_rdata); else passed++;
    checks++; if (err_m !== 1'b0) $display("FAIL stall_bus_error: got %b want 0", err_m); else passed++;
    cpu_m.d_read = 0;
    $display("load addr=00000044 after 5 stalls rdata=%h", cpu_m.d_rdata);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    cpu_t.d_read = 1; cpu_t.d_addr = 32'h0000_0080; cpu_t.d_byteenable = 4'hF;
    bus_t.waitrequest = 1; bus_t.readdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if ({bus_t.read, cpu_t.d_ready} !== 2'b10) $display("FAIL to_stall%0d: got %b want 10", k, {bus_t.read, cpu_t.d_ready}); else passed++;
    end
    @(negedge clk);
    checks++; if (bus_t.read !== 1'b0) $display("FAIL to_strobe_drop: got %b want 0", bus_t.read); else passed++;
    checks++; if (cpu_t.d_ready !== 1'b1) $display("FAIL to_d_ready: got %b want 1", cpu_t.d_ready); else passed++;
    checks++; if (cpu_t.d_rdata !== 32'h0) $display("FAIL to_d_rdata: got %h want 0", cpu_t.d_rdata); else passed++;
    checks++; if (err_t !== 1'b1) $display("FAIL to_bus_error: got %b want 1", err_t); else passed++;
    cpu_t.d_read = 0; bus_t.waitrequest = 0;
    $display("load addr=00000080 aborted by timeout");
    repeat (3) @(negedge clk);
    checks++; if ({err_t, cpu_t.d_ready} !== 2'b10) $display("FAIL to_sticky: got %b want 10", {err_t, cpu_t.d_ready}); else passed++;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cpu_m.if_req = 1; cpu_m.if_addr = 32'h0000_0300;
    bus_m.waitrequest = 1; bus_m.readdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (bus_m.read !== 1'b1) $display("FAIL mid_read_active: got %b want 1", bus_m.read); else passed++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus_m.read !== 1'b0) $display("FAIL mid_async_read: got %b want 0", bus_m.read); else passed++;
    checks++; if (bus_m.address !== 32'h0) $display("FAIL mid_async_address: got %h want 0", bus_m.address); else passed++;
    checks++; if (err_t !== 1'b0) $display("FAIL mid_err_cleared: got %b want 0", err_t); else passed++;
    cpu_m.if_req = 0; bus_m.waitrequest = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({cpu_m.if_ready, bus_m.read} !== 2'b00) $display("FAIL mid_no_ready%0d: got %b want 00", k, {cpu_m.if_ready, bus_m.read}); else passed++;
    end
    cpu_m.if_req = 1; cpu_m.if_addr = 32'h0000_0400; bus_m.readdata = 32'h600D_CAFE;
    @(negedge clk);
    checks++; if ({bus_m.read, bus_m.address} !== {1'b1, 32'h0000_0400}) $display("FAIL mid_refetch_bus: got %b/%h want 1/00000400", bus_m.read, bus_m.address); else passed++;
    @(negedge clk);
    checks++; if ({cpu_m.if_ready, cpu_m.if_rdata} !== {1'b1, 32'h600D_CAFE}) $display("FAIL mid_refetch_done: got %b/%h want 1/600dcafe", cpu_m.if_ready, cpu_m.if_rdata); else passed++;
    cpu_m.if_req = 0;
    $display("fetch addr=00000400 after reset rdata=%h", cpu_m.if_rdata);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch_only();
    test_data_priority();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
